// File: rtl/sw_sampler_if.sv
// sw_sampler_if
//   Groups the switch sampler's board-side level inputs, its debounced
//   output and the change-event handshake into one bundle.
//
//   Signals:
//     sw_raw      [NSW]  asynchronous board switch levels
//     sw_stable   [NSW]  debounced switch vector
//     evt_valid          change event pending
//     evt_mask    [NSW]  bits flipped since the last acknowledge
//     evt_overrun        further change while an event was pending
//     evt_ack            consumer acknowledge
//
//   Modports:
//     master  - the sampler (drives sw_stable and the event outputs)
//     slave   - board/consumer side (drives sw_raw and evt_ack)
interface sw_sampler_if #(
  parameter int NSW = 10
);
  logic [NSW-1:0] sw_raw;
  logic [NSW-1:0] sw_stable;
  logic           evt_valid;
  logic [NSW-1:0] evt_mask;
  logic           evt_overrun;
  logic           evt_ack;

  modport master (
    input  sw_raw,
    input  evt_ack,
    output sw_stable,
    output evt_valid,
    output evt_mask,
    output evt_overrun
  );

  modport slave (
    output sw_raw,
    output evt_ack,
    input  sw_stable,
    input  evt_valid,
    input  evt_mask,
    input  evt_overrun
  );
endinterface

// File: rtl/sw_sampler.sv
// sw_sampler
//   Synchronizes and debounces NSW board switches and reports changes of
//   the debounced vector as an accumulated, acknowledgeable event.
//
//   Each raw level passes a two-flop synchronizer. On every sample tick a
//   per-bit 8-bit counter counts consecutive ticks on which the
//   synchronized level differs from the debounced level; after
//   STABLE_TICKS such ticks the debounced bit takes the new level. Any
//   tick on which the levels agree restarts the count.
//
//   Debounced bits flipping in a cycle are ORed into evt_mask and raise
//   evt_valid together with the sw_stable update. A flip arriving while an
//   event is already pending and not being acknowledged sets evt_overrun.
//
//   Parameters:
//     NSW           number of switch inputs
//     STABLE_TICKS  consecutive differing ticks before a flip (1..255)
//     TICK_DIV      clocks per sample tick when prescaling (2..2^24)
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high; clears all state
//     bus    sw_sampler_if.master (sw_raw, sw_stable, evt_* handshake)
//
//   Build option:
//     SW_SAMPLER_PRESCALE_EN  when defined, a 24-bit prescaler produces one
//                             tick every TICK_DIV clocks; otherwise every
//                             clock is a tick and no prescaler is built.
module sw_sampler #(
  parameter int NSW          = 10,
  parameter int STABLE_TICKS = 16,
  parameter int TICK_DIV     = 50000
) (
  input  logic          clk,
  input  logic          reset,
  sw_sampler_if.master  bus
);

  if (STABLE_TICKS < 1 || STABLE_TICKS > 255) begin : gBadStableTicks
    $error("sw_sampler: STABLE_TICKS must be within 1..255");
  end
  if (TICK_DIV < 2 || TICK_DIV > 2**24) begin : gBadTickDiv
    $error("sw_sampler: TICK_DIV must be within 2..2^24");
  end

  localparam logic [7:0] LAST_CNT = 8'(STABLE_TICKS - 1);

  logic           tick;
  logic [NSW-1:0] sync_p0;
  logic [NSW-1:0] sync_p1;
  logic [7:0]     cnt [NSW];
  logic [NSW-1:0] stableNext;
  logic [NSW-1:0] flipVec;
  logic           ackAccepted;

  // ---- sample tick generation ----
`ifdef SW_SAMPLER_PRESCALE_EN
  localparam logic [23:0] PRE_LAST = 24'(TICK_DIV - 1);

  logic [23:0] preCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      preCnt <= '0;
    end else if (preCnt == PRE_LAST) begin
      preCnt <= '0;
    end else begin
      preCnt <= preCnt + 24'd1;
    end
  end

  assign tick = (preCnt == PRE_LAST);
`else
  assign tick = 1'b1;
`endif

  // ---- stage p0/p1: two-flop synchronizer, only sync_p1 is used downstream ----
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.sw_raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- debounce: decide which debounced bits flip at this edge ----
  always_comb begin
    stableNext = bus.sw_stable;
    for (int i = 0; i < NSW; i++) begin
      if (tick && (sync_p1[i] != bus.sw_stable[i]) && (cnt[i] == LAST_CNT)) begin
        stableNext[i] = sync_p1[i];
      end
    end
  end

  assign flipVec     = stableNext ^ bus.sw_stable;
  assign ackAccepted = bus.evt_valid & bus.evt_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sw_stable <= '0;
      for (int i = 0; i < NSW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      bus.sw_stable <= stableNext;
      if (tick) begin
        for (int i = 0; i < NSW; i++) begin
          // Agreement restarts the run; reaching the last count flips the
          // bit (via stableNext) and also restarts.
          if ((sync_p1[i] == bus.sw_stable[i]) || (cnt[i] == LAST_CNT)) begin
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // ---- change event, registered alongside the sw_stable update ----
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.evt_valid   <= 1'b0;
      bus.evt_mask    <= '0;
      bus.evt_overrun <= 1'b0;
    end else if (flipVec != '0) begin
      bus.evt_valid <= 1'b1;
      if (ackAccepted) begin
        // The old event is consumed; the new flips start a fresh one.
        bus.evt_mask    <= flipVec;
        bus.evt_overrun <= 1'b0;
      end else begin
        bus.evt_mask <= bus.evt_mask | flipVec;
        if (bus.evt_valid) begin
          bus.evt_overrun <= 1'b1;
        end
      end
    end else if (ackAccepted) begin
      bus.evt_valid   <= 1'b0;
      bus.evt_mask    <= '0;
      bus.evt_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sw_sampler.sv
// tb_sw_sampler
//   Scoreboard bench for sw_sampler. A reference model samples the inputs
//   on every rising edge and queues the outputs it expects after that edge;
//   a monitor pops and compares on the falling edge. The debounce rule is
//   modelled as a sliding window: a debounced bit flips when the last
//   STABLE_TICKS tick samples of its synchronized level all differ from it.
//   Directed spec scenarios queue extra, constant expectations tied to a
//   specific falling edge.
module tb_sw_sampler;
  localparam int NSW = 10;
`ifdef SW_SAMPLER_PRESCALE_EN
  localparam int STABLE_TICKS = 2;
  localparam int TICK_DIV     = 4;
  localparam bit PRESCALE     = 1'b1;
`else
  localparam int STABLE_TICKS = 4;
  localparam int TICK_DIV     = 2;
  localparam bit PRESCALE     = 1'b0;
`endif
  localparam logic [NSW-1:0] ALL = '1;

  typedef struct packed {
    logic [NSW-1:0] stable;
    logic           vld;
    logic [NSW-1:0] mask;
    logic           ovr;
  } snap_t;

  typedef struct {
    string          name;
    int             at;
    logic [NSW-1:0] care;
    logic [NSW-1:0] stab;
    logic           vld;
    logic [NSW-1:0] mask;
    logic           ovr;
  } dir_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sw_sampler_if #(.NSW(NSW)) bus ();

  sw_sampler #(
    .NSW(NSW),
    .STABLE_TICKS(STABLE_TICKS),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  snap_t expQ[$];
  dir_t  dirQ[$];
  int    compared = 0;
  int    mismatched = 0;
  bit    modelStarted = 1'b0;
  int    negCnt = 0;

  // Reference model: one step per rising edge.
  initial begin : model
    logic [NSW-1:0] m1, m2, mStable, mMask, syncNow, newStable, flip;
    logic           mValid, mOvr, acc, tick, allDiff;
    logic [NSW-1:0] hist[$];
    int             cyc;
    m1 = '0; m2 = '0; mStable = '0; mMask = '0; mValid = 0; mOvr = 0; cyc = 0;
    forever begin
      @(posedge clk);
      modelStarted = 1'b1;
      if (reset) begin
        m1 = '0; m2 = '0; mStable = '0; mMask = '0;
        mValid = 0; mOvr = 0; cyc = 0;
        hist.delete();
      end else begin
        syncNow = m2;
        m2 = m1;
        m1 = bus.sw_raw;
        tick = PRESCALE ? ((cyc % TICK_DIV) == TICK_DIV - 1) : 1'b1;
        cyc++;
        newStable = mStable;
        if (tick) begin
          hist.push_back(syncNow);
          if (hist.size() > STABLE_TICKS) void'(hist.pop_front());
          for (int b = 0; b < NSW; b++) begin
            allDiff = (hist.size() == STABLE_TICKS);
            foreach (hist[k]) if (hist[k][b] == mStable[b]) allDiff = 1'b0;
            if (allDiff) newStable[b] = ~mStable[b];
          end
        end
        flip = newStable ^ mStable;
        acc = mValid && bus.evt_ack;
        if (flip != '0) begin
          if (acc) begin
            mMask = flip;
            mOvr = 1'b0;
          end else begin
            mMask = mMask | flip;
            mOvr = mOvr | mValid;
          end
          mValid = 1'b1;
        end else if (acc) begin
          mValid = 1'b0; mMask = '0; mOvr = 1'b0;
        end
        mStable = newStable;
      end
      expQ.push_back('{stable: mStable, vld: mValid, mask: mMask, ovr: mOvr});
    end
  end

  // Monitor: compares on the falling edge.
  initial begin : monitor
    snap_t e;
    dir_t  d;
    forever begin
      @(negedge clk);
      if (modelStarted) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("FAIL scoreboard at edge %0d: got an output with no expectation queued", negCnt);
        end else begin
          e = expQ.pop_front();
          if (bus.sw_stable !== e.stable || bus.evt_valid !== e.vld ||
              bus.evt_mask !== e.mask || bus.evt_overrun !== e.ovr) begin
            mismatched++;
            $display("FAIL model edge %0d: got stable=%h valid=%b mask=%h ovr=%b, expected stable=%h valid=%b mask=%h ovr=%b",
                     negCnt, bus.sw_stable, bus.evt_valid, bus.evt_mask, bus.evt_overrun,
                     e.stable, e.vld, e.mask, e.ovr);
          end
        end
        while (dirQ.size() > 0 && dirQ[0].at <= negCnt) begin
          d = dirQ.pop_front();
          compared++;
          if (d.at != negCnt || (bus.sw_stable & d.care) !== d.stab || bus.evt_valid !== d.vld ||
              bus.evt_mask !== d.mask || bus.evt_overrun !== d.ovr) begin
            mismatched++;
            $display("FAIL %s: got stable&care=%h valid=%b mask=%h ovr=%b, expected %h %b %h %b",
                     d.name, bus.sw_stable & d.care, bus.evt_valid, bus.evt_mask, bus.evt_overrun,
                     d.stab, d.vld, d.mask, d.ovr);
          end
        end
        negCnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expect values at the falling edge after the j-th following rising edge
  // (j=0: the falling edge of the current cycle).
  task automatic expectIn(input string name, input int j, input logic [NSW-1:0] care,
                          input logic [NSW-1:0] stab, input logic vld,
                          input logic [NSW-1:0] mask, input logic ovr);
    dir_t d;
    d.name = name; d.at = negCnt + j; d.care = care; d.stab = stab;
    d.vld = vld; d.mask = mask; d.ovr = ovr;
    dirQ.push_back(d);
  endtask

  initial begin : stimulus
    reset = 1'b1;
    bus.sw_raw = '0;
    bus.evt_ack = 1'b0;
    step(3);
    expectIn("reset_state", 0, ALL, '0, 1'b0, '0, 1'b0);
    reset = 1'b0;
`ifndef SW_SAMPLER_PRESCALE_EN
    // Clean edge on bit 0: flips exactly 6 clocks later.
    bus.sw_raw[0] = 1'b1;
    expectIn("edge_latency_before", 5, 10'h001, 10'h000, 1'b0, 10'h000, 1'b0);
    expectIn("edge_latency_flip", 6, 10'h001, 10'h001, 1'b1, 10'h001, 1'b0);
    step(8);
    // Bit 5 flips while bit 0's event is pending.
    bus.sw_raw[5] = 1'b1;
    expectIn("overrun_accumulate", 6, 10'h021, 10'h021, 1'b1, 10'h021, 1'b1);
    step(6);
    bus.evt_ack = 1'b1;
    expectIn("ack_clears", 1, 10'h021, 10'h021, 1'b0, 10'h000, 1'b0);
    step(1);
    bus.evt_ack = 1'b0;
    step(2);
    // Glitch of STABLE_TICKS-1 clocks on bit 3 is rejected.
    bus.sw_raw[3] = 1'b1;
    step(3);
    bus.sw_raw[3] = 1'b0;
    expectIn("glitch_rejected", 8, 10'h008, 10'h000, 1'b0, 10'h000, 1'b0);
    step(10);
    // Ack in the same cycle bit 2 flips.
    bus.sw_raw[1] = 1'b1;
    step(8);
    bus.sw_raw[2] = 1'b1;
    step(5);
    bus.evt_ack = 1'b1;
    expectIn("ack_with_flip", 1, 10'h004, 10'h004, 1'b1, 10'h004, 1'b0);
    step(1);
    step(1);
    bus.evt_ack = 1'b0;
    // Reset with a counter at STABLE_TICKS-1 and an event pending.
    bus.sw_raw[4] = 1'b1;
    step(8);
    bus.sw_raw[6] = 1'b1;
    step(5);
    reset = 1'b1;
    bus.sw_raw = '0;
    expectIn("reset_mid_debounce", 1, ALL, '0, 1'b0, '0, 1'b0);
    step(2);
    reset = 1'b0;
    expectIn("post_reset_1", 1, ALL, '0, 1'b0, '0, 1'b0);
    expectIn("post_reset_2", 2, ALL, '0, 1'b0, '0, 1'b0);
    expectIn("post_reset_3", 3, ALL, '0, 1'b0, '0, 1'b0);
    step(4);
`else
    // Held edge on bit 9 through the prescaled tick.
    bus.sw_raw[9] = 1'b1;
    step(24);
`endif
    // Switches high at reset release.
    reset = 1'b1;
    bus.sw_raw = ALL;
    step(2);
    reset = 1'b0;
    step(40);
    // Randomized phase.
    repeat (3000) begin
      for (int b = 0; b < NSW; b++) begin
        if ($urandom_range(0, PRESCALE ? 31 : 15) == 0) bus.sw_raw[b] = ~bus.sw_raw[b];
      end
      bus.evt_ack = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step(1);
    end
    reset = 1'b0;
    bus.evt_ack = 1'b0;
    step(30);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
